// File: rtl/dma_ctrl_slave_mc.sv
// dma_ctrl_slave_mc: NUM_CH-channel DMA descriptor slave with round-robin launch onto a shared read/write master pair.
// Define CTRL_TIMEOUT_EN to add a per-job watchdog that flags ERR after TIMEOUT_CYCLES busy cycles.
module dma_ctrl_slave_mc #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_W         = $clog2(NUM_CH) + 2,
  parameter int TIMEOUT_CYCLES = 1 << 20,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iChip_select,
  input  logic              iWrite,
  input  logic              iRead,
  input  logic [ADDR_W-1:0] iAddress,
  input  logic [31:0]       iWrite_data,
  input  logic              iWM_done,
  output logic [31:0]       oRead_data,
  output logic              oRM_start,
  output logic              oWM_start,
  output logic [31:0]       oSrc_address,
  output logic [31:0]       oDest_address,
  output logic [31:0]       oLength,
  output logic [CH_W-1:0]   oActive_ch,
  output logic              oIrq
);
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_CMPL = 2'd2;
  logic [1:0]        r_state;
  logic [31:0]       r_src [NUM_CH];
  logic [31:0]       r_dst [NUM_CH];
  logic [31:0]       r_len [NUM_CH];
  logic [NUM_CH-1:0] r_pend, r_busy, r_done, r_irq_en, w_err;
  logic [CH_W-1:0]   w_ch, w_sel, w_idx;
  logic [1:0]        w_off;
  logic              w_hit, w_wr, w_lock, w_any, w_done_ev, w_to_ev;

  assign w_off     = iAddress[1:0];
  assign w_ch      = CH_W'(iAddress >> 2);
  assign w_hit     = int'(iAddress >> 2) < NUM_CH;
  assign w_wr      = iChip_select && iWrite && w_hit;
  assign w_lock    = r_pend[w_ch] || r_busy[w_ch];
  assign w_done_ev = (r_state == S_BUSY) && iWM_done;
  assign oIrq      = |((r_done | w_err) & r_irq_en);

  // lowest rotation distance from the last launched channel wins
  always_comb begin
    w_sel = oActive_ch;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = CH_W'((int'(oActive_ch) + 1 + k) % NUM_CH);
      if (r_pend[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_src[k] <= '0;
        r_dst[k] <= '0;
        r_len[k] <= '0;
      end
      r_pend        <= '0;
      r_busy        <= '0;
      r_done        <= '0;
      r_irq_en      <= '0;
      r_state       <= S_IDLE;
      oRM_start     <= 1'b0;
      oWM_start     <= 1'b0;
      oSrc_address  <= '0;
      oDest_address <= '0;
      oLength       <= '0;
      oActive_ch    <= '0;
    end else begin
      oRM_start <= 1'b0;
      oWM_start <= 1'b0;
      if (w_wr && w_off == 2'd3) begin
        r_irq_en[w_ch] <= iWrite_data[1];
        if (iWrite_data[2]) r_done[w_ch] <= 1'b0;
        if (iWrite_data[0] && !w_lock) begin
          if (r_len[w_ch] == '0) r_done[w_ch] <= 1'b1;
          else r_pend[w_ch] <= 1'b1;
        end
      end
      if (w_wr && !w_lock) begin
        if (w_off == 2'd0) r_src[w_ch] <= iWrite_data;
        if (w_off == 2'd1) r_dst[w_ch] <= iWrite_data;
        if (w_off == 2'd2) r_len[w_ch] <= iWrite_data;
      end
      // scheduler updates come last so a completion's DONE set beats a same-cycle DONE_CLR
      case (r_state)
        S_IDLE: if (w_any) begin
          oSrc_address  <= r_src[w_sel];
          oDest_address <= r_dst[w_sel];
          oLength       <= r_len[w_sel];
          oActive_ch    <= w_sel;
          oRM_start     <= 1'b1;
          oWM_start     <= 1'b1;
          r_pend[w_sel] <= 1'b0;
          r_busy[w_sel] <= 1'b1;
          r_state       <= S_BUSY;
        end
        S_BUSY: if (w_done_ev || w_to_ev) begin
          r_busy[oActive_ch] <= 1'b0;
          if (w_done_ev) r_done[oActive_ch] <= 1'b1;
          r_state <= S_CMPL;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) oRead_data <= '0;
    else if (iChip_select && iRead)
      oRead_data <= !w_hit ? '0 :
                    w_off == 2'd0 ? r_src[w_ch] :
                    w_off == 2'd1 ? r_dst[w_ch] :
                    w_off == 2'd2 ? r_len[w_ch] :
                    {27'd0, r_irq_en[w_ch], w_err[w_ch], r_pend[w_ch], r_done[w_ch], r_busy[w_ch]};
  end

`ifdef CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     r_tcnt;
  logic [NUM_CH-1:0] r_err;
  assign w_to_ev = (r_state == S_BUSY) && !iWM_done && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_err   = r_err;
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_tcnt <= '0;
      r_err  <= '0;
    end else begin
      r_tcnt <= (r_state == S_BUSY) ? r_tcnt + TW'(1) : '0;
      if (w_wr && w_off == 2'd3 && iWrite_data[3]) r_err[w_ch] <= 1'b0;
      if (w_to_ev) r_err[oActive_ch] <= 1'b1;
    end
  end
`else
  assign w_to_ev = 1'b0;
  assign w_err   = '0;
`endif
endmodule
